// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the PC / fetch-control stage.
// Holds the FSM state encoding and the address/index widths used by the top.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_D          = 12;
  localparam int DEF_START_ADDR = 0;
  localparam int LUT_IDX_W      = 8;

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Combinational next-PC selection: hold, absolute branch target, or pc+1.
// Flags the modulo wrap of the sequential increment; a branch target never wraps.
module pc_fetch_ctrl_pc_next_sel #(
  parameter int D = 12
) (
  input  logic [D-1:0] i_pc,
  input  logic [D-1:0] i_lut_target,
  input  logic         i_hold,
  input  logic         i_take_branch,
  output logic [D-1:0] o_pc_next,
  output logic         o_wrap
);

  logic [D-1:0] w_pc_inc;

  assign w_pc_inc = i_pc + {{(D-1){1'b0}}, 1'b1};

  always_comb begin
    o_pc_next = i_pc;
    o_wrap    = 1'b0;
    if (i_hold) begin
      o_pc_next = i_pc;
    end else if (i_take_branch) begin
      o_pc_next = i_lut_target;
    end else begin
      o_pc_next = w_pc_inc;
      o_wrap    = &i_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencing ahead of the branch-target LUT and IMEM.
// Owns the IDLE/RUN/DONE FSM, the retired-instruction counter and the wrap flag.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int D          = DEF_D,
  parameter int START_ADDR = DEF_START_ADDR,
  parameter int CW         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [LUT_IDX_W-1:0] lut_addr,
  input  logic [D-1:0]         lut_target,
  output logic [D-1:0]         pc,
  output logic                 fetch_en,
  output logic                 done,
  output logic [CW-1:0]        instr_count,
  output logic                 wrap_err,
  output logic [1:0]           dbg_state
);

  localparam logic [D-1:0] L_START = D'(START_ADDR);

  state_t        r_state;
  state_t        w_state_next;
  logic [D-1:0]  r_pc;
  logic [CW-1:0] r_count;
  logic          r_wrap_err;

  logic [D-1:0]  w_pc_next;
  logic          w_wrap;
  logic          w_advance;
  logic          w_load_start;
  logic [CW-1:0] w_count_inc;

  // Handshake: start is a one-cycle pulse honoured only in IDLE or DONE; done is a
  // level that stays high in DONE until the cycle after the next accepted start.
  assign w_advance    = (r_state == ST_RUN) && !stall;
  assign w_load_start = (r_state != ST_RUN) && start;
  assign w_count_inc  = (&r_count) ? r_count : r_count + {{(CW-1){1'b0}}, 1'b1};

  pc_fetch_ctrl_pc_next_sel #(
    .D (D)
  ) u_pc_next_sel (
    .i_pc          (r_pc),
    .i_lut_target  (lut_target),
    .i_hold        (halt),
    .i_take_branch (branch_en && branch_taken),
    .o_pc_next     (w_pc_next),
    .o_wrap        (w_wrap)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (!stall && halt) w_state_next = ST_DONE;
      ST_DONE: if (start) w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= L_START;
      r_count    <= '0;
      r_wrap_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_start) begin
        r_pc       <= L_START;
        r_count    <= '0;
        r_wrap_err <= 1'b0;
      end else if (w_advance) begin
        r_pc    <= w_pc_next;
        r_count <= w_count_inc;
        if (w_wrap) r_wrap_err <= 1'b1;
      end
    end
  end

  assign lut_addr    = branch_idx;
  assign pc          = r_pc;
  assign instr_count = r_count;
  assign wrap_err    = r_wrap_err;
  assign fetch_en    = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a behavioural model predicts each cycle's
// state, pushes it to exp_q when inputs are driven, and pops it after the edge.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam int D  = 12;
  localparam int CW = 5;
  localparam int W  = 2 + D + CW + 1;
  localparam logic [D-1:0]  PC_MAX  = 12'd4095;
  localparam logic [CW-1:0] CNT_MAX = 5'd31;

  logic          clk;
  logic          reset_n;
  logic          start, halt, stall, branch_en, branch_taken;
  logic [7:0]    branch_idx;
  logic [7:0]    lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  pc;
  logic          fetch_en, done, wrap_err;
  logic [CW-1:0] instr_count;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_errors;

  logic [1:0]    m_state;
  logic [D-1:0]  m_pc;
  logic [CW-1:0] m_cnt;
  logic          m_wrap;
  logic [W-1:0]  exp_q[$];

  pc_fetch_ctrl #(.D(D), .START_ADDR(0), .CW(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .pc           (pc),
    .fetch_en     (fetch_en),
    .done         (done),
    .instr_count  (instr_count),
    .wrap_err     (wrap_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_pc    = '0;
    m_cnt   = '0;
    m_wrap  = 1'b0;
  endtask

  task automatic compare_outputs(input logic [W-1:0] e);
    logic [1:0]    e_state;
    logic [D-1:0]  e_pc;
    logic [CW-1:0] e_cnt;
    logic          e_wrap;
    {e_state, e_pc, e_cnt, e_wrap} = e;
    check_val("state", 32'(dbg_state), 32'(e_state));
    check_val("pc", 32'(pc), 32'(e_pc));
    check_val("instr_count", 32'(instr_count), 32'(e_cnt));
    check_val("wrap_err", 32'(wrap_err), 32'(e_wrap));
    check_val("fetch_en", 32'(fetch_en), 32'(e_state == ST_RUN));
    check_val("done", 32'(done), 32'(e_state == ST_DONE));
  endtask

  // driver: one clock of stimulus, model prediction pushed, DUT result popped
  task automatic step(input logic st, input logic hl, input logic sl, input logic be,
                      input logic bt, input logic [7:0] idx, input logic [D-1:0] tgt);
    logic [W-1:0] e;
    @(negedge clk);
    start = st; halt = hl; stall = sl; branch_en = be; branch_taken = bt;
    branch_idx = idx; lut_target = tgt;
    #1;
    check_val("lut_addr", 32'(lut_addr), 32'(idx));
    if (m_state != ST_RUN) begin
      if (st) begin
        m_state = ST_RUN; m_pc = '0; m_cnt = '0; m_wrap = 1'b0;
      end
    end else if (!sl) begin
      m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1'b1;
      if (hl) begin
        m_state = ST_DONE;
      end else if (be && bt) begin
        m_pc = tgt;
      end else begin
        if (m_pc == PC_MAX) m_wrap = 1'b1;
        m_pc = m_pc + 1'b1;
      end
    end
    exp_q.push_back({m_state, m_pc, m_cnt, m_wrap});
    @(posedge clk);
    #1;
    start = 1'b0;
    e = exp_q.pop_front();
    compare_outputs(e);
  endtask

  task automatic do_start();                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0); endtask
  task automatic plain();                   step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0); endtask
  task automatic br(input logic [D-1:0] t); step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, t); endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; branch_taken = 1'b0; branch_idx = '0; lut_target = '0;
    model_reset();
    #2;
    compare_outputs({m_state, m_pc, m_cnt, m_wrap});
    @(negedge clk);
    reset_n = 1'b1;

    // sequential fetch after start
    plain();
    do_start();
    repeat (3) plain();

    // taken and not-taken branch at pc=5
    plain(); plain();
    check_val("pc_at_5", 32'(pc), 32'd5);
    br(12'd503);
    br(12'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 12'd503);

    // stall with every other control asserted, then the branch resolves
    br(12'd10);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7, 12'd700);
    br(12'd700);

    // halt beats a taken branch, DONE holds, start restarts
    br(12'd20);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 12'd900);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 12'd900);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
    do_start();
    plain();

    // wrap past the top of the address space, start ignored in RUN
    br(PC_MAX);
    plain();
    br(12'd100);
    br(12'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
    do_start();

    // retired counter saturates
    repeat (40) plain();

    // async reset mid-run at pc=300
    br(12'd300);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("async_pc", 32'(pc), 32'd0);
    check_val("async_fetch_en", 32'(fetch_en), 32'd0);
    check_val("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd9, 12'd55);
    do_start();

    // random mix
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           12'($urandom_range(3900, 4095)));
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
